// File: rtl/score_keeper.sv
// score_keeper: match controller that sits downstream of the ball stage.
// On each frame tick it checks whether the ball has reached a goal column
// without paddle cover, awards the point, holds the ball stage in reset for
// a serve pause, and ends the match once a player reaches WIN_SCORE.
//
// Ports
//   clock       system clock
//   reset       asynchronous active-high reset
//   tick        one-cycle frame strobe (aligned with the ball position update)
//   start       level; begins the match from IDLE, restarts it from OVER
//   ball_x/y    ball position
//   player_1_y  top row of the left paddle (defends MIN_H)
//   player_2_y  top row of the right paddle (defends MAX_H)
//   ball_reset  holds the ball stage at its serve position
//   score_1/2   player scores
//   point_1/2   one-cycle pulse when the respective player scores
//   game_over   high while the match is over
//   state       IDLE=0, PLAY=1, PAUSE=2, OVER=3
module score_keeper #(
  parameter int unsigned MIN_H       = 0,
  parameter int unsigned MAX_H       = 320,
  parameter int unsigned PADDLE_LEN  = 32,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned PAUSE_TICKS = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [8:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [8:0] player_1_y,
  input  logic [8:0] player_2_y,
  output logic       ball_reset,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       point_1,
  output logic       point_2,
  output logic       game_over,
  output logic [1:0] state
);

  localparam int unsigned CW = (PAUSE_TICKS < 2) ? 1 : $clog2(PAUSE_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          ball_reset_q, ball_reset_d;
  logic [3:0]    score_1_q, score_1_d;
  logic [3:0]    score_2_q, score_2_d;
  logic          point_1_q, point_1_d;
  logic          point_2_q, point_2_d;
  logic          game_over_q, game_over_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Cover test at 10 bits so a paddle near row 511 extends past 511
  // instead of wrapping back to the top of the screen.
  logic [9:0] p1_top, p1_bot, p2_top, p2_bot, by_w;
  logic       cover_1, cover_2, miss_left, miss_right;

  always_comb begin
    by_w       = {1'b0, ball_y};
    p1_top     = {1'b0, player_1_y};
    p2_top     = {1'b0, player_2_y};
    p1_bot     = p1_top + 10'(PADDLE_LEN - 1);
    p2_bot     = p2_top + 10'(PADDLE_LEN - 1);
    cover_1    = (by_w >= p1_top) && (by_w <= p1_bot);
    cover_2    = (by_w >= p2_top) && (by_w <= p2_bot);
    miss_left  = (ball_x == 9'(MIN_H)) && !cover_1;
    miss_right = (ball_x == 9'(MAX_H)) && !cover_2;
  end

  always_comb begin
    state_d      = state_q;
    ball_reset_d = ball_reset_q;
    score_1_d    = score_1_q;
    score_2_d    = score_2_q;
    point_1_d    = 1'b0;
    point_2_d    = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      IDLE: begin
        ball_reset_d = 1'b1;
        if (start) begin
          state_d      = PLAY;
          ball_reset_d = 1'b0;
        end
      end
      PLAY: begin
        if (tick && miss_left) begin
          score_2_d    = score_2_q + 4'd1;
          point_2_d    = 1'b1;
          ball_reset_d = 1'b1;
          if (score_2_d == 4'(WIN_SCORE)) begin
            state_d = OVER;
          end else begin
            state_d = PAUSE;
            cnt_d   = CW'(PAUSE_TICKS);
          end
        end else if (tick && miss_right) begin
          score_1_d    = score_1_q + 4'd1;
          point_1_d    = 1'b1;
          ball_reset_d = 1'b1;
          if (score_1_d == 4'(WIN_SCORE)) begin
            state_d = OVER;
          end else begin
            state_d = PAUSE;
            cnt_d   = CW'(PAUSE_TICKS);
          end
        end
      end
      PAUSE: begin
        ball_reset_d = 1'b1;
        if (tick) begin
          // <=1 also recovers if the counter were ever found at zero.
          if (cnt_q <= CW'(1)) begin
            state_d      = PLAY;
            ball_reset_d = 1'b0;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      OVER: begin
        ball_reset_d = 1'b1;
        if (start) begin
          score_1_d = '0;
          score_2_d = '0;
          state_d   = PAUSE;
          cnt_d     = CW'(PAUSE_TICKS);
        end
      end
      default: state_d = IDLE;
    endcase

    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ball_reset_q <= 1'b1;
      score_1_q    <= '0;
      score_2_q    <= '0;
      point_1_q    <= 1'b0;
      point_2_q    <= 1'b0;
      game_over_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ball_reset_q <= ball_reset_d;
      score_1_q    <= score_1_d;
      score_2_q    <= score_2_d;
      point_1_q    <= point_1_d;
      point_2_q    <= point_2_d;
      game_over_q  <= game_over_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ball_reset = ball_reset_q;
  assign score_1    = score_1_q;
  assign score_2    = score_2_q;
  assign point_1    = point_1_q;
  assign point_2    = point_2_q;
  assign game_over  = game_over_q;
  assign state      = state_q;

endmodule

// File: doc/score_keeper.md
# score_keeper

Match controller downstream of the ball stage. Each frame tick it watches the ball position and both paddle positions, and detects when a ball reaches a goal edge without paddle cover. On a miss it awards the point, holds the ball stage in reset for a serve pause, and ends the match at a target score. Its `ball_reset` output drives the ball stage's reset input; its scores feed the display stage.

## Interface
- `MIN_H`, 0: left goal column; player 1 defends it.
- `MAX_H`, 320: right goal column; player 2 defends it.
- `PADDLE_LEN`, 32: paddle height in pixels; the paddle covers rows `player_y` .. `player_y+PADDLE_LEN-1`.
- `WIN_SCORE`, 9: score that ends the match. Range 1..15.
- `PAUSE_TICKS`, 60: serve pause length in ticks. Must be ≥1.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle frame strobe, coincident with the ball stage's position update.
- `start` in 1: level; begins or restarts the match.
- `ball_x` in 9: ball horizontal position.
- `ball_y` in 9: ball vertical position.
- `player_1_y` in 9: top row of the left paddle.
- `player_2_y` in 9: top row of the right paddle.
- `ball_reset` out 1: holds the ball stage at its serve position.
- `score_1` out 4: player 1 score.
- `score_2` out 4: player 2 score.
- `point_1` out 1: one-cycle pulse when player 1 scores.
- `point_2` out 1: one-cycle pulse when player 2 scores.
- `game_over` out 1: high while in OVER.
- `state` out 2: IDLE=0, PLAY=1, PAUSE=2, OVER=3.

## Operation
- All outputs are registered.
- Reset values: `state`=IDLE, `ball_reset`=1, `score_1`=`score_2`=0, `point_1`=`point_2`=0, `game_over`=0, pause counter=0.
- **Cover test**: `ball_y` ≥ `player_y` and `ball_y` ≤ `player_y`+`PADDLE_LEN`-1. Evaluate at 10-bit width so a paddle near row 511 does not wrap.
- **IDLE**:
  - `ball_reset`=1.
  - `start`=1 at an edge → PLAY and `ball_reset`=0. This transition does not depend on `tick`.
- **PLAY**: on an edge where `tick`=1:
  - Left miss: `ball_x`==`MIN_H` and player 1 paddle does not cover → `score_2`+1, `point_2` pulse.
  - Right miss: `ball_x`==`MAX_H` and player 2 paddle does not cover → `score_1`+1, `point_1` pulse.
  - After a miss: `ball_reset`=1. Next state is OVER if the incremented score equals `WIN_SCORE`, otherwise PAUSE with the counter loaded to `PAUSE_TICKS`.
  - Both misses cannot occur together, since `MIN_H`≠`MAX_H`.
  - A covered ball at a goal column, or any position between the goals: no action.
  - `tick`=0: no evaluation.
- **PAUSE**:
  - `ball_reset`=1.
  - Each tick decrements the counter.
  - A tick while the counter is 1 → PLAY, `ball_reset`=0.
  - `start` is ignored.
- **OVER**:
  - `game_over`=1, `ball_reset`=1, scores frozen.
  - `start`=1 → clear both scores, `game_over`=0, go to PAUSE with the counter loaded.
- Scores never exceed `WIN_SCORE` and never wrap.
- `point_*` pulses are exactly one clock wide and are never high together.

## Timing
- Miss latency:
  - The miss is sampled at the tick edge N.
  - From edge N: score updated, `point_*`=1, `ball_reset`=1, `state`=PAUSE/OVER.
  - From edge N+1: `point_*`=0.
- Pause length:
  - `ball_reset` stays high for exactly `PAUSE_TICKS` ticks after entering PAUSE.
  - It falls on the edge of the `PAUSE_TICKS`-th tick.
  - A tick coincident with the entry edge is not counted.
- IDLE→PLAY: `ball_reset` falls on the first edge with `start`=1.
- Asynchronous reset mid-PAUSE or mid-PLAY: all outputs go to their reset values immediately and the pause counter clears. A pulse in flight is dropped.
- A `ball_x` change without `tick` never triggers a point.

## Test plan
- **Reset and start**: assert `reset`, release, hold `start`=1 one cycle → `state` IDLE→PLAY, `ball_reset` 1→0, scores 0.
- **Left miss**: `ball_x`=0, `ball_y`=100, `player_1_y`=20, tick → `score_2`=1, `point_2` high exactly 1 cycle, `state`=PAUSE. With `PAUSE_TICKS`=3, `ball_reset` falls on the 3rd subsequent tick.
- **Right-paddle boundary**: `ball_x`=320, `player_2_y`=50.
  - `ball_y`=81 with tick → no point.
  - `ball_y`=82 with tick → `score_1`+1.
  - `ball_y`=49 with tick → `score_1`+1.
- **Win and restart**: `WIN_SCORE`=2, two right misses → `score_1`=2, `state`=OVER, `game_over`=1. Further ticks leave scores unchanged. `start` → scores 0, `state`=PAUSE.
- **Mid-pause reset**: assert `reset` asynchronously between clock edges during PAUSE → outputs reach reset values before the next edge, `state`=IDLE.
- **Paddle wrap**: `player_1_y`=500, `ball_y`=5, `ball_x`=0, tick → miss is counted, with no false cover from 9-bit wrap.
